axis_frame_rr_arbiter: RTL and testbench

Frame-granular round-robin arbiter. It merges NUM_IN 64-bit AXI-Stream frame sources onto one 10G MAC TX stream, for example two SFP RX loopback FIFOs feeding one MAC's s_axis_tx port. A grant is held from the first beat of a frame to the accepted tlast beat, so frames are never interleaved. Per-input frame counters are exported for VIO monitoring.

---
 rtl/axis_frame_rr_arbiter.sv | 88 ++++++++
 tb/tb_axis_frame_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_rr_arbiter.sv
// axis_frame_rr_arbiter: merges NUM_IN AXI-Stream frame sources onto one stream,
// granting whole frames round-robin and counting forwarded frames per input.
module axis_frame_rr_arbiter #(
    parameter int NUM_IN     = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32,
    parameter int IDX_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             s_axis_tvalid,
    output logic [NUM_IN-1:0]             s_axis_tready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_IN*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_IN-1:0]             s_axis_tlast,
    input  logic [NUM_IN-1:0]             s_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic                          busy,
    output logic [NUM_IN*CNT_WIDTH-1:0]   frame_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] data_a [NUM_IN];
    logic [KEEP_WIDTH-1:0] keep_a [NUM_IN];
    logic [CNT_WIDTH-1:0]  cnt    [NUM_IN];
    logic [IDX_WIDTH-1:0]  pick;
    logic                  pick_vld;
    logic                  frame_end;
    int                    best;
    int                    off;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        assign data_a[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign keep_a[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        assign frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

    // Distance from the last grant; the requester closest after grant_idx wins.
    always_comb begin
        pick     = grant_idx;
        pick_vld = |s_axis_tvalid;
        best     = NUM_IN;
        off      = 0;
        for (int j = 0; j < NUM_IN; j++) begin
            off = (j + 2 * NUM_IN - 1 - int'(grant_idx)) % NUM_IN;
            if (s_axis_tvalid[j] && off < best) begin
                best = off;
                pick = IDX_WIDTH'(j);
            end
        end
    end

    assign busy          = (state == BUSY);
    assign m_axis_tvalid = busy & s_axis_tvalid[grant_idx];
    assign m_axis_tdata  = data_a[grant_idx];
    assign m_axis_tkeep  = keep_a[grant_idx];
    assign m_axis_tlast  = s_axis_tlast[grant_idx];
    assign m_axis_tuser  = s_axis_tuser[grant_idx];
    assign frame_end     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        s_axis_tready            = '0;
        s_axis_tready[grant_idx] = busy & m_axis_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= IDX_WIDTH'(NUM_IN - 1);
            for (int j = 0; j < NUM_IN; j++) cnt[j] <= '0;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                grant_idx <= pick;
                state     <= BUSY;
            end
        end else if (frame_end) begin
            state          <= IDLE;
            cnt[grant_idx] <= cnt[grant_idx] + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// tb_axis_frame_rr_arbiter: directed frames on two inputs, expected beats scoreboarded
// in a queue; a narrow-counter twin instance shares the stimulus to exercise wrap.
module tb_axis_frame_rr_arbiter;
    localparam int N = 2, DW = 64, KW = 8, CW = 32, WW = 2;
    typedef struct packed {
        logic          v;
        logic          u;
        logic          l;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] s_tvalid, s_tready, s_tlast, s_tuser, w_s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic m_tvalid, m_tready, m_tlast, m_tuser, busy;
    logic w_m_tvalid, w_m_tlast, w_m_tuser, w_busy;
    logic [DW-1:0] m_tdata, w_m_tdata;
    logic [KW-1:0] m_tkeep, w_m_tkeep;
    logic [0:0] grant_idx, w_grant_idx;
    logic [N*CW-1:0] frame_cnt;
    logic [N*WW-1:0] w_frame_cnt;

    beat_t src_q [N][$];
    beat_t exp_q [$];
    int    hs_q [$];
    int    cyc = 0;
    int    c_cmp = 0, c_bad = 0, m_cmp = 0, m_bad = 0;

    axis_frame_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy), .frame_cnt(frame_cnt)
    );

    axis_frame_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .CNT_WIDTH(WW)) dut_w (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(w_s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(w_m_tdata),
        .m_axis_tkeep(w_m_tkeep), .m_axis_tlast(w_m_tlast), .m_axis_tuser(w_m_tuser),
        .grant_idx(w_grant_idx), .busy(w_busy), .frame_cnt(w_frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t fb(input int t, input int s, input int f, input int nb, input int i);
        beat_t b;
        b.v = 1'b1;
        b.l = (i == nb - 1);
        b.k = b.l ? 8'h0F : 8'hFF;
        b.u = b.l & f[0];
        b.d = {8'(t), 8'(s), 8'(f), 8'(i), 32'(t * 4096 + s * 256 + f * 16 + i) ^ 32'h5A5A_C3C3};
        return b;
    endfunction

    function automatic logic [CW-1:0] cnt(input int i);
        return frame_cnt[i*CW +: CW];
    endfunction

    function automatic logic [WW-1:0] wcnt(input int i);
        return w_frame_cnt[i*WW +: WW];
    endfunction

    // A frame queued on source s; gap_len invalid cycles are inserted before beat gap_at.
    task automatic send(input int t, input int s, input int f, input int nb,
                        input int gap_at = -1, input int gap_len = 0);
        for (int i = 0; i < nb; i++) begin
            if (i == gap_at) for (int j = 0; j < gap_len; j++) src_q[s].push_back(beat_t'(0));
            src_q[s].push_back(fb(t, s, f, nb, i));
        end
    endtask

    task automatic expect_f(input int t, input int s, input int f, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(fb(t, s, f, nb, i));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        c_cmp++;
        if (act !== req) begin
            c_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        c_cmp++;
        if (n >= budget) begin
            c_bad++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
            exp_q.delete();
            for (int i = 0; i < N; i++) src_q[i].delete();
        end
    endtask

    // Source driver: handshake judged on pre-edge values, new beat presented 2 units later.
    initial begin
        beat_t h;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (src_q[i].size() > 0 && (!src_q[i][0].v || (s_tvalid[i] && s_tready[i])))
                    void'(src_q[i].pop_front());
            #2;
            for (int i = 0; i < N; i++) begin
                h = (src_q[i].size() > 0) ? src_q[i][0] : beat_t'(0);
                s_tvalid[i]           = h.v;
                s_tdata[i*DW +: DW]   = h.d;
                s_tkeep[i*KW +: KW]   = h.k;
                s_tlast[i]            = h.l;
                s_tuser[i]            = h.u;
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            m_cmp++;
            if ($countones(s_tready) > 1) begin
                m_bad++;
                $display("FAIL tready_onehot: got %b, required at most one bit set", s_tready);
            end
            if (m_tvalid && m_tready) begin
                hs_q.push_back(cyc);
                m_cmp++;
                if (exp_q.size() == 0) begin
                    m_bad++;
                    $display("FAIL unexpected_beat: got data %h, required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tuser, m_tlast, m_tkeep, m_tdata} !== {e.u, e.l, e.k, e.d}) begin
                        m_bad++;
                        $display("FAIL beat: got u%b l%b k%h d%h, required u%b l%b k%h d%h",
                                 m_tuser, m_tlast, m_tkeep, m_tdata, e.u, e.l, e.k, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int t0, base, n;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant_idx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_cnt0", cnt(0), 0);
        chk("rst_cnt1", cnt(1), 0);
        rst = 1'b0;
        m_tready = 1'b1;

        // Single 3-beat frame on input 0: one arbitration cycle, then pass-through.
        @(posedge clk); #1;
        t0 = cyc; base = hs_q.size();
        send(1, 0, 0, 3); expect_f(1, 0, 0, 3);
        wait_drain(50);
        chk("t1_latency", (hs_q.size() > base) ? hs_q[base] - t0 : -1, 1);
        chk("t1_cnt0", cnt(0), 1);
        chk("t1_grant", grant_idx, 0);
        chk("t1_busy", busy, 0);

        // Both inputs with 4 queued 2-beat frames; grant was 0, so input 1 leads.
        @(posedge clk); #1;
        base = hs_q.size();
        for (int f = 0; f < 4; f++) begin send(2, 0, f, 2); send(2, 1, f, 2); end
        for (int f = 0; f < 4; f++) begin expect_f(2, 1, f, 2); expect_f(2, 0, f, 2); end
        wait_drain(120);
        chk("t2_beats", hs_q.size() - base, 16);
        chk("t2_span", (hs_q.size() >= base + 16) ? hs_q[base+15] - hs_q[base] : -1, 22);
        chk("t2_cnt0", cnt(0), 5);
        chk("t2_cnt1", cnt(1), 4);
        chk("t2_grant", grant_idx, 0);

        // 5-beat frame on input 1 under toggling ready; input 0 requests mid-frame.
        @(posedge clk); #1;
        send(3, 1, 0, 5); expect_f(3, 1, 0, 5); expect_f(3, 0, 1, 1);
        n = 0;
        while (src_q[1].size() > 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) send(3, 0, 1, 1);
            m_tready = ~m_tready;
            chk("t3_sready0", s_tready[0], 0);
        end
        m_tready = 1'b1;
        wait_drain(60);
        chk("t3_cnt0", cnt(0), 6);
        chk("t3_cnt1", cnt(1), 5);
        chk("t3_grant", grant_idx, 0);

        // Input 1 stalls 3 cycles mid-frame while input 0 waits.
        @(posedge clk); #1;
        base = hs_q.size();
        send(4, 1, 0, 4, 2, 3); send(4, 0, 1, 2);
        expect_f(4, 1, 0, 4); expect_f(4, 0, 1, 2);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("t4_busy", busy, 1);
            chk("t4_mvalid", m_tvalid, 0);
            chk("t4_grant", grant_idx, 1);
            @(negedge clk);
        end
        wait_drain(60);
        chk("t4_gap", (hs_q.size() >= base + 3) ? hs_q[base+2] - hs_q[base+1] : -1, 4);
        chk("t4_cnt0", cnt(0), 7);
        chk("t4_cnt1", cnt(1), 6);
        chk("t4_wcnt0_allones", wcnt(0), 3);
        chk("t4_wcnt1", wcnt(1), 2);

        // One more frame on input 0 wraps the 2-bit twin counter from all-ones to 0.
        @(posedge clk); #1;
        send(5, 0, 0, 1); expect_f(5, 0, 0, 1);
        wait_drain(40);
        chk("t5_wcnt0_wrap", wcnt(0), 0);
        chk("t5_cnt0", cnt(0), 8);

        // Reset during beat 2 of a 4-beat frame; only beat 1 reaches the output.
        @(posedge clk); #1;
        send(6, 0, 0, 4); exp_q.push_back(fb(6, 0, 0, 4, 0));
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        src_q[0].delete();
        #1;
        chk("t6_mvalid", m_tvalid, 0);
        chk("t6_sready", s_tready, 0);
        chk("t6_busy", busy, 0);
        @(posedge clk); #1;
        chk("t6_grant", grant_idx, 1);
        chk("t6_cnt0", cnt(0), 0);
        chk("t6_wcnt0", wcnt(0), 0);
        chk("t6_leftover", exp_q.size(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        send(6, 1, 1, 1); send(6, 0, 2, 1);
        expect_f(6, 0, 2, 1); expect_f(6, 1, 1, 1);
        wait_drain(40);
        chk("t6_cnt0_after", cnt(0), 1);
        chk("t6_cnt1_after", cnt(1), 1);
        chk("t6_grant_after", grant_idx, 1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", c_cmp + m_cmp, c_bad + m_bad);
        $finish;
    end
endmodule
